serial_adder: RTL
=================

Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor; successor to the single-bit and two-bit combinational adders.
- Computes an N-bit A+B or A-B over WIDTH clock cycles using one full-adder slice and a stored carry.
- Uses a start/busy/done handshake, so the switch/LED top level or a later controller can request operations and read held results.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request operation; sampled on rising clk
- sub  input  1  0 = add, 1 = subtract (A - B); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when result becomes valid
- sum  output  WIDTH  result, held until next completion
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow (a >= b unsigned)
- overflow  output  1  signed two's-complement overflow of the completed operation

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy = 0; done = 0; sum = 0; cout = 0; overflow = 0; internal shift registers, carry and bit counter cleared. Reset is honoured mid-operation: the operation is abandoned and no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start = 1, latch a into shift register SA and b XOR {WIDTH{sub}} into SB.
  - Load carry with sub; clear bit counter; go to RUN.
  - start = 0: stay.
- RUN:
  - busy = 1.
  - Each cycle: s = SA[0] ^ SB[0] ^ carry; carry <= majority(SA[0], SB[0], carry).
  - Shift SA, SB right; shift s into the MSB of the partial-sum register; increment counter.
  - On the cycle processing bit WIDTH-1 (counter = WIDTH-1), capture into output registers at that edge:
    - sum <= completed partial sum;
    - cout <= final carry;
    - overflow <= carry into MSB XOR carry out of MSB.
  - Then go to DONE.
  - start is ignored while in RUN; no queuing.
- DONE:
  - busy = 0; done = 1 for exactly this one cycle.
  - If start = 1 in this cycle, the new request is accepted exactly as in IDLE and the next state is RUN (back-to-back). Otherwise go to IDLE.
- Latency: start sampled at edge k → RUN occupies edges k+1..k+WIDTH → sum/cout/overflow update at edge k+WIDTH → done high for the cycle after that edge. Throughput: one result per WIDTH+1 cycles in back-to-back operation.
- Outputs sum/cout/overflow change only at completion or reset; they stay stable throughout a subsequent RUN.
- Operands a, b and sub may change freely after the start cycle without affecting the operation in progress.
- Arithmetic is modulo 2^WIDTH.
  - Add: {cout, sum} = a + b.
  - Subtract: sum = a + ~b + 1.
- Counter width: clog2(WIDTH) bits, minimum 1. No wrap-around beyond WIDTH-1.

Test Plan:
- WIDTH=8, add 0x5A + 0x3C → after 8 RUN cycles: sum = 0x96, cout = 0, overflow = 1; done high exactly 1 cycle; busy high exactly 8 cycles.
- Add 0xFF + 0x01 → sum = 0x00, cout = 1, overflow = 0. Subtract 0x10 - 0x20 → sum = 0xF0, cout = 0 (borrow), overflow = 0.
- Subtract 0x80 - 0x01 → sum = 0x7F, cout = 1, overflow = 1. Add 0x7F + 0x7F → sum = 0xFE, cout = 0, overflow = 1.
- Assert start in the DONE cycle with 0x01 + 0x02 → no IDLE gap; done pulses again WIDTH+1 cycles later; sum = 0x03. Previous sum is held unchanged through the second RUN.
- Pulse start again mid-RUN and change a/b after the start cycle → ignored; result matches the originally latched operands.
- Deassert rst_n at RUN cycle 4 → all outputs 0 immediately (asynchronous); no done pulse after release; a fresh start then completes normally.
- Repeat the add/subtract vectors at WIDTH=2 (3 + 1 → sum 0, cout 1) and WIDTH=16 (0x8000 - 0x0001 → 0x7FFF, overflow 1).

Source files
------------

// File: rtl/serial_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_adder : bit-serial WIDTH-bit add/subtract, one bit per clock
// Revision     : 1.0
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   ps_q, ps_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic w_s_bit;
  logic w_c_next;
  logic w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ps_q    <= ps_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    ps_d     = ps_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    w_accept = 1'b0;
    w_s_bit  = sa_q[0] ^ sb_q[0] ^ carry_q;
    w_c_next = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);

    case (state_q)
      IDLE: w_accept = start;
      RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        ps_d    = {w_s_bit, ps_q[WIDTH-1:1]};
        carry_d = w_c_next;
        if (cnt_q == C_LAST) begin
          // carry_q here is the carry into the MSB slice
          sum_d   = {w_s_bit, ps_q[WIDTH-1:1]};
          cout_d  = w_c_next;
          ovf_d   = carry_q ^ w_c_next;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      DONE: begin
        w_accept = start;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Subtract is a + ~b + 1: invert b and seed the carry with 1
    if (w_accept) begin
      sa_d    = a;
      sb_d    = b ^ {WIDTH{sub}};
      ps_d    = '0;
      carry_d = sub;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire
